// File: rtl/gpio_serial_loader.sv
`default_nettype none
// ============================================================================
// Module   : gpio_serial_loader
// Purpose  : Loads both GPIO control-block shift chains from per-pad config
//            words on one start strobe; bit-bang override while idle.
// Revision : 1.0 - initial release
// ============================================================================
module gpio_serial_loader #(
  parameter int N1    = 19,
  parameter int N2    = 19,
  parameter int CFG_W = 13,
  parameter int DIV   = 2,
  parameter int AW    = 6
) (
  input  logic             clock,
  input  logic             resetb,
  input  logic             start,
  output logic [AW-1:0]    cfg_addr,
  input  logic [CFG_W-1:0] cfg_rdata1,
  input  logic [CFG_W-1:0] cfg_rdata2,
  input  logic             bb_enable,
  input  logic             bb_clock,
  input  logic             bb_load,
  input  logic             bb_resetn,
  input  logic             bb_data1,
  input  logic             bb_data2,
  output logic             serial_clock,
  output logic             serial_load,
  output logic             serial_resetn,
  output logic             serial_data_1,
  output logic             serial_data_2,
  output logic             busy,
  output logic             done
);

  localparam int c_M  = (N1 > N2) ? N1 : N2;
  localparam int c_CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int c_BW = (CFG_W > 1) ? $clog2(CFG_W) : 1;
  localparam logic [AW-1:0]   c_ADDR_LAST = AW'(c_M - 1);
  localparam logic [c_CW-1:0] c_DIV_LAST  = c_CW'(DIV - 1);
  localparam logic [c_BW-1:0] c_BIT_LAST  = c_BW'(CFG_W - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_SHIFT = 2'd2,
    S_LOAD  = 2'd3
  } state_t;

  state_t            r_state;
  logic [c_CW-1:0]   r_div_cnt;
  logic [c_BW-1:0]   r_bit_cnt;
  logic              r_phase_hi;
  logic [CFG_W-1:0]  r_sr1;
  logic [CFG_W-1:0]  r_sr2;
  logic              w_pad1;
  logic              w_pad2;

  // The shorter chain shifts zeros for word indices it does not have, so both end together.
  assign w_pad1 = 32'(cfg_addr) >= 32'(N1);
  assign w_pad2 = 32'(cfg_addr) >= 32'(N2);

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_state       <= S_IDLE;
      r_div_cnt     <= '0;
      r_bit_cnt     <= '0;
      r_phase_hi    <= 1'b0;
      r_sr1         <= '0;
      r_sr2         <= '0;
      cfg_addr      <= '0;
      serial_clock  <= 1'b0;
      serial_load   <= 1'b0;
      serial_resetn <= 1'b0;
      serial_data_1 <= 1'b0;
      serial_data_2 <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_div_cnt  <= '0;
          r_bit_cnt  <= '0;
          r_phase_hi <= 1'b0;
          if (bb_enable) begin
            serial_clock  <= bb_clock;
            serial_load   <= bb_load;
            serial_resetn <= bb_resetn;
            serial_data_1 <= bb_data1;
            serial_data_2 <= bb_data2;
          end else begin
            serial_clock  <= 1'b0;
            serial_load   <= 1'b0;
            serial_resetn <= 1'b1;
            serial_data_1 <= 1'b0;
            serial_data_2 <= 1'b0;
            if (start) begin
              r_state  <= S_FETCH;
              cfg_addr <= c_ADDR_LAST;
              busy     <= 1'b1;
            end
          end
        end

        S_FETCH: begin
          r_sr1         <= w_pad1 ? '0 : cfg_rdata1;
          r_sr2         <= w_pad2 ? '0 : cfg_rdata2;
          serial_data_1 <= ~w_pad1 & cfg_rdata1[CFG_W-1];
          serial_data_2 <= ~w_pad2 & cfg_rdata2[CFG_W-1];
          r_div_cnt     <= '0;
          r_bit_cnt     <= '0;
          r_phase_hi    <= 1'b0;
          r_state       <= S_SHIFT;
        end

        S_SHIFT: begin
          if (r_div_cnt != c_DIV_LAST) begin
            r_div_cnt <= r_div_cnt + 1'b1;
          end else begin
            r_div_cnt <= '0;
            if (!r_phase_hi) begin
              r_phase_hi   <= 1'b1;
              serial_clock <= 1'b1;
            end else begin
              // Data advances only on the falling edge, keeping it stable across the rise.
              r_phase_hi   <= 1'b0;
              serial_clock <= 1'b0;
              if (r_bit_cnt != c_BIT_LAST) begin
                r_bit_cnt     <= r_bit_cnt + 1'b1;
                r_sr1         <= {r_sr1[CFG_W-2:0], 1'b0};
                r_sr2         <= {r_sr2[CFG_W-2:0], 1'b0};
                serial_data_1 <= r_sr1[CFG_W-2];
                serial_data_2 <= r_sr2[CFG_W-2];
              end else if (cfg_addr != '0) begin
                cfg_addr <= cfg_addr - 1'b1;
                r_state  <= S_FETCH;
              end else begin
                serial_load <= 1'b1;
                r_state     <= S_LOAD;
              end
            end
          end
        end

        S_LOAD: begin
          if (r_div_cnt != c_DIV_LAST) begin
            r_div_cnt <= r_div_cnt + 1'b1;
          end else begin
            r_div_cnt     <= '0;
            serial_load   <= 1'b0;
            serial_data_1 <= 1'b0;
            serial_data_2 <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b1;
            r_state       <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gpio_serial_loader.sv
`default_nettype none
// Testbench for gpio_serial_loader: two chain configurations, table-driven load runs
// with random words checked against a word-level chain model, plus bit-bang and reset sequences.
module tb_gpio_serial_loader;
  localparam int CW  = 13;
  localparam int AWT = 2;

  logic clock  = 1'b0;
  logic resetb = 1'b1;
  always #5 clock = ~clock;

  logic [1:0] start = '0;
  logic [1:0] bb_en = '0;
  logic [1:0] clr   = '0;
  logic bb_clk = 1'b0, bb_ld = 1'b0, bb_rn = 1'b0, bb_d1 = 1'b0, bb_d2 = 1'b0;

  logic [CW-1:0]  mem1 [2][4];
  logic [CW-1:0]  mem2 [2][4];
  logic [AWT-1:0] addr [2];
  logic [CW-1:0]  rd1  [2];
  logic [CW-1:0]  rd2  [2];
  logic [1:0] sclk, sld, srn, sd1, sd2, busy, done;

  assign rd1[0] = mem1[0][addr[0]];
  assign rd2[0] = mem2[0][addr[0]];
  assign rd1[1] = mem1[1][addr[1]];
  assign rd2[1] = mem2[1][addr[1]];

  gpio_serial_loader #(.N1(2), .N2(2), .CFG_W(CW), .DIV(1), .AW(AWT)) dut_a (
    .clock(clock), .resetb(resetb), .start(start[0]), .cfg_addr(addr[0]),
    .cfg_rdata1(rd1[0]), .cfg_rdata2(rd2[0]), .bb_enable(bb_en[0]),
    .bb_clock(bb_clk), .bb_load(bb_ld), .bb_resetn(bb_rn), .bb_data1(bb_d1), .bb_data2(bb_d2),
    .serial_clock(sclk[0]), .serial_load(sld[0]), .serial_resetn(srn[0]),
    .serial_data_1(sd1[0]), .serial_data_2(sd2[0]), .busy(busy[0]), .done(done[0]));

  gpio_serial_loader #(.N1(3), .N2(1), .CFG_W(CW), .DIV(2), .AW(AWT)) dut_b (
    .clock(clock), .resetb(resetb), .start(start[1]), .cfg_addr(addr[1]),
    .cfg_rdata1(rd1[1]), .cfg_rdata2(rd2[1]), .bb_enable(bb_en[1]),
    .bb_clock(1'b0), .bb_load(1'b0), .bb_resetn(1'b0), .bb_data1(1'b0), .bb_data2(1'b0),
    .serial_clock(sclk[1]), .serial_load(sld[1]), .serial_resetn(srn[1]),
    .serial_data_1(sd1[1]), .serial_data_2(sd2[1]), .busy(busy[1]), .done(done[1]));

  // Chain-side monitor: captures data on each serial_clock rise and tallies pulse widths.
  int busy_cyc[2], load_cyc[2], done_cnt[2], done_bad[2], unstable[2], ovl[2], ncap[2];
  logic [63:0] cap1[2];
  logic [63:0] cap2[2];
  logic [1:0] p_clk = '0, p_d1 = '0, p_d2 = '0, p_busy = '0;

  always @(negedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (clr[i]) begin
        busy_cyc[i] <= 0; load_cyc[i] <= 0; done_cnt[i] <= 0;
        done_bad[i] <= 0; unstable[i] <= 0; ncap[i] <= 0;
        cap1[i] <= '0; cap2[i] <= '0;
      end else begin
        if (busy[i]) busy_cyc[i] <= busy_cyc[i] + 1;
        if (busy[i] && sld[i]) load_cyc[i] <= load_cyc[i] + 1;
        if (done[i]) begin
          done_cnt[i] <= done_cnt[i] + 1;
          if (busy[i] || !p_busy[i]) done_bad[i] <= done_bad[i] + 1;
        end
        if (busy[i] && sclk[i] && !p_clk[i] && ncap[i] < 64) begin
          cap1[i][ncap[i]] <= sd1[i];
          cap2[i][ncap[i]] <= sd2[i];
          ncap[i] <= ncap[i] + 1;
          if (sd1[i] !== p_d1[i] || sd2[i] !== p_d2[i]) unstable[i] <= unstable[i] + 1;
        end
      end
      assert (!(sclk[i] && sld[i])) else begin
        $display("FAIL clk_load_overlap inst=%0d serial_clock=%b serial_load=%b required not both 1",
                 i, sclk[i], sld[i]);
        ovl[i] <= ovl[i] + 1;
      end
    end
    p_clk  <= sclk;
    p_d1   <= sd1;
    p_d2   <= sd2;
    p_busy <= busy;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Word expected in the k-th shifted slot: indices run M-1 down to 0, absent indices are zeros.
  function automatic logic [CW-1:0] exp_word(input int i, input int chain, input int k);
    int n;
    int m;
    int w;
    m = (i == 0) ? 2 : 3;
    if (chain == 1) n = (i == 0) ? 2 : 3;
    else            n = (i == 0) ? 2 : 1;
    w = m - 1 - k;
    if (w >= n) return '0;
    return (chain == 1) ? mem1[i][w] : mem2[i][w];
  endfunction

  typedef struct {
    int              inst;
    int              mode;      // 0 plain, 1 second start mid-shift, 2 bb_enable raised mid-run
    logic [3*CW-1:0] c1;
    logic [3*CW-1:0] c2;
    int              exp_busy;
  } run_t;

  typedef struct {
    logic [4:0] drive;          // {clock, load, resetn, data1, data2}
    logic [4:0] exp;
  } bb_t;

  run_t runs[6];
  bb_t  bbv[5];

  task automatic do_run(input run_t r);
    int i;
    int m;
    int guard;
    logic [CW-1:0] g1;
    logic [CW-1:0] g2;
    i = r.inst;
    m = (i == 0) ? 2 : 3;
    for (int w = 0; w < 3; w++) begin
      mem1[i][w] = r.c1[w*CW +: CW];
      mem2[i][w] = r.c2[w*CW +: CW];
    end
    mem1[i][3] = CW'($urandom);
    mem2[i][3] = CW'($urandom);
    @(posedge clock); #1 clr[i] = 1'b1;
    @(negedge clock); #1 clr[i] = 1'b0;
    @(posedge clock); #1 start[i] = 1'b1;
    @(posedge clock); #1 start[i] = 1'b0;
    if (r.mode == 1) begin
      repeat (20) @(posedge clock);
      #1 start[i] = 1'b1;
      @(posedge clock); #1 start[i] = 1'b0;
    end
    if (r.mode == 2) begin
      repeat (10) @(posedge clock);
      #1 bb_en[i] = 1'b1;
    end
    guard = 0;
    while (done_cnt[i] == 0 && guard < 1000) begin
      @(negedge clock); #1 guard++;
    end
    chk($sformatf("done_seen_inst%0d", i), (guard < 1000) ? 32'd1 : 32'd0, 32'd1);
    if (r.mode == 2) begin
      chk("bb_idle_at_done", {sclk[i], sld[i], srn[i], sd1[i], sd2[i]}, 5'b00100);
      @(posedge clock); #1;
      chk("bb_after_done", {sclk[i], sld[i], srn[i], sd1[i], sd2[i]},
          {bb_clk, bb_ld, bb_rn, bb_d1, bb_d2});
    end
    repeat (4) @(negedge clock);
    #1;
    chk($sformatf("done_count_inst%0d", i), done_cnt[i], 1);
    chk($sformatf("done_timing_inst%0d", i), done_bad[i], 0);
    chk($sformatf("busy_cycles_inst%0d", i), busy_cyc[i], r.exp_busy);
    chk($sformatf("load_cycles_inst%0d", i), load_cyc[i], (i == 0) ? 1 : 2);
    chk($sformatf("data_stable_inst%0d", i), unstable[i], 0);
    chk($sformatf("rise_count_inst%0d", i), ncap[i], m * CW);
    for (int k = 0; k < m; k++) begin
      for (int j = 0; j < CW; j++) begin
        g1[CW-1-j] = cap1[i][k*CW + j];
        g2[CW-1-j] = cap2[i][k*CW + j];
      end
      chk($sformatf("chain1_word_inst%0d_slot%0d", i, k), g1, exp_word(i, 1, k));
      chk($sformatf("chain2_word_inst%0d_slot%0d", i, k), g2, exp_word(i, 2, k));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] prev;

    runs[0] = '{0, 0, {13'h0000, 13'h1803, 13'h0403}, {13'h0000, 13'h0001, 13'h1FFF}, 55};
    runs[1] = '{1, 0, {CW'($urandom), CW'($urandom), CW'($urandom)},
                {(CW'($urandom) | CW'(1)), (CW'($urandom) | CW'(1)), CW'($urandom)}, 161};
    runs[2] = '{0, 1, {CW'($urandom), CW'($urandom), CW'($urandom)},
                {CW'($urandom), CW'($urandom), CW'($urandom)}, 55};
    runs[3] = '{1, 1, {CW'($urandom), CW'($urandom), CW'($urandom)},
                {CW'($urandom), CW'($urandom), CW'($urandom)}, 161};
    runs[4] = '{0, 0, {CW'($urandom), CW'($urandom), CW'($urandom)},
                {CW'($urandom), CW'($urandom), CW'($urandom)}, 55};
    runs[5] = '{0, 2, {CW'($urandom), CW'($urandom), CW'($urandom)},
                {CW'($urandom), CW'($urandom), CW'($urandom)}, 55};

    bbv[0] = '{5'b10100, 5'b10100};
    bbv[1] = '{5'b00110, 5'b00110};
    bbv[2] = '{5'b10001, 5'b10001};
    bbv[3] = '{5'b01110, 5'b01110};
    bbv[4] = '{5'b00000, 5'b00000};

    for (int i = 0; i < 2; i++)
      for (int w = 0; w < 4; w++) begin
        mem1[i][w] = '0;
        mem2[i][w] = '0;
      end

    // Reset values and serial_resetn release timing.
    #1 resetb = 1'b0;
    clr = 2'b11;
    #2;
    chk("reset_outputs_a", {sclk[0], sld[0], srn[0], sd1[0], sd2[0], busy[0], done[0], addr[0]}, 0);
    chk("reset_outputs_b", {sclk[1], sld[1], srn[1], sd1[1], sd2[1], busy[1], done[1], addr[1]}, 0);
    #4 resetb = 1'b1;
    #1 chk("resetn_low_before_first_edge", srn, 2'b00);
    @(posedge clock); #1;
    chk("resetn_high_after_first_edge", srn, 2'b11);
    @(negedge clock); #1 clr = 2'b00;

    for (int r = 0; r < 5; r++) do_run(runs[r]);

    // Bit-bang override in idle: pins follow one cycle late.
    prev = 5'b00100;
    @(posedge clock); #1 bb_en[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      {bb_clk, bb_ld, bb_rn, bb_d1, bb_d2} = bbv[k].drive;
      #1 chk($sformatf("bb_latency_%0d", k), {sclk[0], sld[0], srn[0], sd1[0], sd2[0]}, prev);
      @(posedge clock); #1;
      chk($sformatf("bb_follow_%0d", k), {sclk[0], sld[0], srn[0], sd1[0], sd2[0]}, bbv[k].exp);
      prev = bbv[k].exp;
    end
    start[0] = 1'b1;
    @(posedge clock); #1 start[0] = 1'b0;
    repeat (3) @(posedge clock);
    #1 chk("start_ignored_in_bb_busy", busy[0], 0);
    chk("start_ignored_in_bb_addr", addr[0], 0);
    bb_en[0] = 1'b0;
    @(posedge clock); #1;
    chk("bb_release_idle_pins", {sclk[0], sld[0], srn[0], sd1[0], sd2[0]}, 5'b00100);

    // bb_enable raised during a run has no effect until after done.
    {bb_clk, bb_ld, bb_rn, bb_d1, bb_d2} = 5'b10011;
    do_run(runs[5]);
    bb_en[0] = 1'b0;
    {bb_clk, bb_ld, bb_rn, bb_d1, bb_d2} = 5'b00000;
    @(posedge clock);

    // Reset in the middle of the first word.
    @(posedge clock); #1 clr[0] = 1'b1;
    @(negedge clock); #1 clr[0] = 1'b0;
    @(posedge clock); #1 start[0] = 1'b1;
    @(posedge clock); #1 start[0] = 1'b0;
    repeat (8) @(posedge clock);
    #3 chk("busy_before_mid_reset", busy[0], 1);
    resetb = 1'b0;
    #1 chk("mid_reset_outputs", {sclk[0], sld[0], srn[0], sd1[0], sd2[0], busy[0], done[0], addr[0]}, 0);
    repeat (2) @(posedge clock);
    #3 resetb = 1'b1;
    #1 chk("mid_reset_resetn_low", srn[0], 0);
    @(posedge clock); #1;
    chk("mid_reset_resetn_high", srn[0], 1);
    repeat (30) @(posedge clock);
    #1 chk("no_load_after_reset", load_cyc[0], 0);
    chk("no_done_after_reset", done_cnt[0], 0);
    do_run(runs[0]);

    @(negedge clock); #1;
    chk("clk_load_overlap_total", ovl[0] + ovl[1], 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
